// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver
// PS/2 keyboard receive front end. Synchronises and filters the raw PS/2
// clock and data lines, deserialises 11-bit device-to-host frames and
// resolves the E0 (extended) and F0 (break) prefix bytes into one scan-code
// event per key action.
//
// Build option: define PS2_PARITY_CHECK_EN to reject frames whose data bits
// plus parity bit do not have odd parity. Without it the parity bit is
// sampled and ignored, and only the stop bit is checked.
//
// Handshake: key_valid, key_release and frame_err are single-cycle,
// mutually exclusive pulses with no back-pressure. key_code/key_ext are
// loaded in the same cycle as key_valid/key_release and hold until the
// next emitted key event. The consumer must accept a pulse the cycle it
// is seen.
//
// fsm_state exposes the frame FSM encoding (0 IDLE, 1 DATA, 2 STOP) for
// observation only.

module ps2_scan_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_valid,
  output logic       key_release,
  output logic       frame_err,
  output logic [1:0] fsm_state
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] BYTE_EXT = 8'hE0;
  localparam logic [7:0] BYTE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t                state;
  logic                  c_meta;
  logic                  c_sync;
  logic                  d_meta;
  logic                  d_sync;
  logic [FILTER_LEN-1:0] c_sr;
  logic                  filt;
  logic                  filt_d;
  logic                  fall;
  logic [3:0]            bit_cnt;
  logic [7:0]            data_sr;
  logic [WD_W-1:0]       wd_cnt;
  logic                  wd_expired;
  logic                  ext;
  logic                  brk;
  logic                  frame_good;

  // Two-flop synchronisers; the idle level of both PS/2 lines is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_meta <= 1'b1;
      c_sync <= 1'b1;
      d_meta <= 1'b1;
      d_sync <= 1'b1;
    end else begin
      c_meta <= ps2c;
      c_sync <= c_meta;
      d_meta <= ps2d;
      d_sync <= d_meta;
    end
  end

  // Clock glitch filter: the level only moves once FILTER_LEN samples agree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_sr   <= '1;
      filt   <= 1'b1;
      filt_d <= 1'b1;
    end else begin
      c_sr   <= {c_sr[FILTER_LEN-2:0], c_sync};
      filt_d <= filt;
      if (&c_sr) begin
        filt <= 1'b1;
      end else if (~|c_sr) begin
        filt <= 1'b0;
      end
    end
  end

  assign fall       = filt_d & ~filt;
  assign wd_expired = (wd_cnt == WD_LAST);
  assign fsm_state  = state;

`ifdef PS2_PARITY_CHECK_EN
  // Running XOR of data and parity bits; odd parity leaves it at 1.
  logic par_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_acc <= 1'b0;
    end else if (state == IDLE) begin
      par_acc <= 1'b0;
    end else if (state == DATA && fall) begin
      par_acc <= par_acc ^ d_sync;
    end
  end

  assign frame_good = d_sync & par_acc;
`else
  assign frame_good = d_sync;
`endif

  // Frame FSM, watchdog, prefix resolution and registered event outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= 4'd0;
      data_sr     <= 8'h00;
      wd_cnt      <= '0;
      ext         <= 1'b0;
      brk         <= 1'b0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      frame_err   <= 1'b0;

      if (state == IDLE || fall) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end

      case (state)
        IDLE: begin
          if (fall && rx_en && !d_sync) begin
            state   <= DATA;
            bit_cnt <= 4'd0;
          end
        end

        DATA: begin
          if (fall) begin
            // Bits 0-7 shift in LSB-first; bit 8 (parity) is not stored.
            if (bit_cnt < 4'd8) begin
              data_sr <= {d_sync, data_sr[7:1]};
            end
            if (bit_cnt == 4'd8) begin
              state <= STOP;
            end
            bit_cnt <= bit_cnt + 4'd1;
          end else if (wd_expired) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            ext       <= 1'b0;
            brk       <= 1'b0;
          end
        end

        STOP: begin
          if (fall) begin
            state <= IDLE;
            if (!frame_good) begin
              frame_err <= 1'b1;
              ext       <= 1'b0;
              brk       <= 1'b0;
            end else if (data_sr == BYTE_EXT) begin
              ext <= 1'b1;
            end else if (data_sr == BYTE_BRK) begin
              brk <= 1'b1;
            end else begin
              key_code    <= data_sr;
              key_ext     <= ext;
              key_release <= brk;
              key_valid   <= ~brk;
              ext         <= 1'b0;
              brk         <= 1'b0;
            end
          end else if (wd_expired) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            ext       <= 1'b0;
            brk       <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb_ps2_scan_receiver
// Drives PS/2 frames on the pad lines and checks every emitted event
// (key_valid / key_release / frame_err together with key_code / key_ext)
// against a reference prefix model that feeds an expected queue.
// Works with or without PS2_PARITY_CHECK_EN defined.

module tb_ps2_scan_receiver;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int HALF           = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2c;
  logic       ps2d;
  logic       rx_en;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_valid;
  logic       key_release;
  logic       frame_err;
  logic [1:0] fsm_state;

  int n_checks = 0;
  int n_errors = 0;

  // Expected event: {valid, release, err, ext, code[7:0]}
  logic [11:0] exp_q[$];

  // Reference prefix model state
  logic       m_ext;
  logic       m_brk;
  logic [7:0] m_code;
  logic       m_key_ext;

  ps2_scan_receiver #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2c       (ps2c),
    .ps2d       (ps2d),
    .rx_en      (rx_en),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_valid  (key_valid),
    .key_release(key_release),
    .frame_err  (frame_err),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
  endtask

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_ext     = 1'b0;
    m_brk     = 1'b0;
    m_code    = 8'h00;
    m_key_ext = 1'b0;
  endtask

  task automatic model_err();
    exp_q.push_back({3'b001, m_key_ext, m_code});
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic bad_par);
`ifdef PS2_PARITY_CHECK_EN
    if (bad_par) begin
      model_err();
      return;
    end
`endif
    if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      m_code    = b;
      m_key_ext = m_ext;
      exp_q.push_back({~m_brk, m_brk, 1'b0, m_ext, b});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_bit(input logic b);
    ps2d = b;
    hold(HALF);
    ps2c = 1'b0;
    hold(HALF);
    ps2c = 1'b1;
  endtask

  // drop_en: release rx_en right after the start bit
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic drop_en);
    model_byte(b, bad_par);
    send_bit(1'b0);
    if (drop_en) rx_en = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(1'b1);
    ps2d = 1'b1;
    hold(2 * HALF);
    rx_en = 1'b1;
  endtask

  // Frame sent while rx_en is low: expected to be ignored entirely.
  task automatic send_frame_disabled(input logic [7:0] b);
    rx_en = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b);
    send_bit(1'b1);
    ps2d = 1'b1;
    hold(2 * HALF);
    rx_en = 1'b1;
  endtask

  task automatic send_partial_then_stall();
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    ps2d = 1'b1;
    model_err();
    hold(TIMEOUT_CYCLES + 10);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && (key_valid || key_release || frame_err)) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_event", {20'd0, key_valid, key_release, frame_err, key_ext, key_code}, 32'd0);
      end else begin
        check_eq("event", {20'd0, key_valid, key_release, frame_err, key_ext, key_code},
                 {20'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic drain(input string tag);
    int budget;
    budget = 500;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rb;
    int r;

    reset = 1'b1;
    ps2c  = 1'b1;
    ps2d  = 1'b1;
    rx_en = 1'b1;
    model_reset();
    hold(4);
    #1;
    check_eq("rst_key_code",    key_code, 8'h00);
    check_eq("rst_key_ext",     key_ext, 1'b0);
    check_eq("rst_key_valid",   key_valid, 1'b0);
    check_eq("rst_key_release", key_release, 1'b0);
    check_eq("rst_frame_err",   frame_err, 1'b0);
    check_eq("rst_fsm",         fsm_state, 2'd0);
    @(posedge clk);
    reset = 1'b0;
    hold(2 * HALF);

    // Make, break, extended make, extended break
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    drain("drain_basic");

    // Bad parity, then a bad-parity prefix followed by a plain key
    send_frame(8'h16, 1'b1, 1'b0);
    send_frame(8'hE0, 1'b1, 1'b0);
    send_frame(8'h2A, 1'b0, 1'b0);
    drain("drain_parity");

    // rx_en low ignores a whole frame; dropping it mid-frame does not abort
    send_frame_disabled(8'h33);
    #1;
    check_eq("rx_en_off_idle", fsm_state, 2'd0);
    send_frame(8'h3B, 1'b0, 1'b1);
    drain("drain_rx_en");

    // Random bytes mixed with prefixes
    for (int i = 0; i < 10; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      rb = 8'hE0;
      else if (r == 1) rb = 8'hF0;
      else             rb = 8'($urandom_range(0, 255));
      send_frame(rb, 1'b0, 1'b0);
    end
    drain("drain_random");

    // Watchdog: stalled frame, then a clean frame
    send_partial_then_stall();
    #1;
    check_eq("timeout_idle", fsm_state, 2'd0);
    send_frame(8'h45, 1'b0, 1'b0);
    drain("drain_timeout");

    // Watchdog clears a pending E0
    send_frame(8'hE0, 1'b0, 1'b0);
    send_partial_then_stall();
    send_frame(8'h45, 1'b0, 1'b0);
    drain("drain_timeout_prefix");

    // Short clock glitches with data low must not start a frame
    ps2d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ps2c = 1'b0;
      hold(FILTER_LEN - 2);
      ps2c = 1'b1;
      hold(HALF);
    end
    ps2d = 1'b1;
    #1;
    check_eq("glitch_idle", fsm_state, 2'd0);
    send_frame(8'h29, 1'b0, 1'b0);
    drain("drain_glitch");

    // Reset during DATA
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    #1;
    check_eq("pre_reset_data", fsm_state, 2'd1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_key_code",  key_code, 8'h00);
    check_eq("mid_rst_key_ext",   key_ext, 1'b0);
    check_eq("mid_rst_pulses",    {key_valid, key_release, frame_err}, 3'b000);
    check_eq("mid_rst_fsm",       fsm_state, 2'd0);
    model_reset();
    ps2d = 1'b1;
    hold(4);
    reset = 1'b0;
    hold(2 * HALF);
    send_frame(8'h1E, 1'b0, 1'b0);
    drain("drain_reset");
    #1;
    check_eq("final_key_code", key_code, 8'h1E);

    hold(50);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ps2_scan_receiver.md
# ps2_scan_receiver

PS/2 keyboard receive front end: filters the raw `ps2c`/`ps2d` lines, deserialises 11-bit device-to-host frames, and resolves the `E0` (extended) and `F0` (break) prefix bytes. It emits one scan code per key event. It sits directly upstream of the scan-code-to-ASCII lookup, which consumes `key_code` qualified by `key_valid`.

## Interface
Parameters:
- `FILTER_LEN`, 8: number of consecutive identical `ps2c` samples needed to change the filtered clock level (≥2).
- `TIMEOUT_CYCLES`, 50000: `clk` cycles allowed between PS/2 falling edges inside a frame before the frame is abandoned.

Ports:
- `clk` input 1: system clock, all logic on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `ps2c` input 1: raw PS/2 clock from pad, asynchronous.
- `ps2d` input 1: raw PS/2 data from pad, asynchronous.
- `rx_en` input 1: permits starting a new frame.
- `key_code` output 8: last emitted scan code; holds until next emission.
- `key_ext` output 1: `key_code` was preceded by `E0`; valid with `key_code`.
- `key_valid` output 1: one-cycle pulse, make event emitted.
- `key_release` output 1: one-cycle pulse, break event emitted.
- `frame_err` output 1: one-cycle pulse, frame discarded.

## Operation
- Sync: `ps2c` and `ps2d` each pass through a 2-flop synchroniser.
- Filter: shift register of `FILTER_LEN` synchronised `ps2c` samples. Filtered clock goes to 1 when all samples are 1 and to 0 when all are 0; otherwise it holds. Reset value is 1.
- Edge: `fall` is a one-cycle pulse on the filtered clock 1→0 transition. All frame sampling uses synchronised `ps2d` in the `fall` cycle.
- Frame FSM states are IDLE, DATA, STOP.
  - IDLE: on `fall` with `rx_en`=1 and `ps2d`=0 (start bit), go to DATA with bit counter 0. On `fall` with `ps2d`=1, or with `rx_en`=0, stay in IDLE.
  - DATA: on each `fall`, shift `ps2d` in LSB-first. Bits 0–7 are data; bit 8 is parity. After bit 8, go to STOP.
  - STOP: on `fall`, sample the stop bit and return to IDLE. A good frame needs stop=1 (and odd parity, see Configuration). A good frame passes its byte to the prefix stage. A bad frame pulses `frame_err`.
- Once a frame has started, `rx_en`=0 does not abort it.
- Watchdog: a counter clears on every `fall` and in IDLE. If it reaches `TIMEOUT_CYCLES`-1 while in DATA or STOP:
  - pulse `frame_err`,
  - go to IDLE,
  - clear the prefix flags.
- Prefix stage holds flags `ext` and `brk`.
  - Byte `E0` sets `ext`.
  - Byte `F0` sets `brk`.
  - Any other byte: load it into `key_code`, load `ext` into `key_ext`, then pulse `key_release` if `brk` else `key_valid`. Clear both flags.
- Prefix bytes never pulse anything.
- `frame_err` clears both prefix flags.
- `key_valid` and `key_release` are never high in the same cycle.

## Timing
- Reset values: `key_code`=8'h00, `key_ext`=0, `key_valid`=0, `key_release`=0, `frame_err`=0, FSM=IDLE, flags=0, counters=0.
- Latency from a pad `ps2c` falling edge to `fall`: 2 (sync) + `FILTER_LEN` cycles, ±1.
- `key_valid`, `key_release` and `frame_err` are asserted in the cycle after the `fall` that samples the stop bit.
- `key_code` and `key_ext` update in that same cycle and are stable while the pulse is high.
- Watchdog `frame_err` is asserted the cycle after the count reaches `TIMEOUT_CYCLES`-1.
- Glitches on `ps2c` shorter than `FILTER_LEN` cycles produce no `fall`.
- Reset mid-frame: all outputs go to their reset values immediately and the partial frame is lost. The first `fall` after reset release is treated as a potential start bit.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: frame is good only if data bits plus parity bit have odd parity. A parity failure pulses `frame_err`, discards the byte and clears the prefix flags.
- `PS2_PARITY_CHECK_EN` undefined: the parity bit is sampled and ignored; only the stop bit is checked.

## Test plan
- Frame 0x1C, parity 0, stop 1 → `key_valid` pulse, `key_code`=0x1C, `key_ext`=0, no `key_release`.
- Frames F0, 1C → no `key_valid`; `key_release` pulse with `key_code`=0x1C, `key_ext`=0.
- Frames E0, 75 → `key_valid` with `key_code`=0x75, `key_ext`=1. Then E0, F0, 75 → `key_release` with `key_code`=0x75, `key_ext`=1.
- Frame 0x16 with parity bit 1:
  - macro defined → `frame_err` pulse, no `key_valid`, `key_code` unchanged;
  - undefined → `key_valid`, `key_code`=0x16.
- Start bit plus 5 data bits, then `ps2c` held high for `TIMEOUT_CYCLES`+10 cycles → one `frame_err` pulse and FSM in IDLE. A following clean 0x45 frame yields `key_valid` with `key_code`=0x45.
- `ps2c` low pulses of `FILTER_LEN`-2 cycles → no state change.
- `reset` asserted during DATA → all outputs 0 that cycle. A clean 0x1E frame after release → `key_code`=0x1E.
